// File: rtl/aes_blk_loader_if.sv
// Bus bundle for aes_blk_loader.
// Groups three streams:
//   - the message word stream: in_valid, in_ready, in_data, in_last;
//   - the AES core handshake: aes_enable, aes_mode, aes_word, aes_result, aes_done;
//   - the processed block stream: out_valid, out_ready, out_data, out_last.
// Modports:
//   - slave: the loader side.
//   - master: the environment, which sources words, models the core and sinks blocks.
interface aes_blk_loader_if #(
   parameter int unsigned TXT_BW = 128,
   parameter int unsigned IN_BW  = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [IN_BW-1:0]  in_data;
   logic              in_last;

   logic              aes_enable;
   logic              aes_mode;
   logic [TXT_BW-1:0] aes_word;
   logic [TXT_BW-1:0] aes_result;
   logic              aes_done;

   logic              out_valid;
   logic              out_ready;
   logic [TXT_BW-1:0] out_data;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, in_last, aes_result, aes_done, out_ready,
      output in_ready, aes_enable, aes_mode, aes_word, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_last, aes_result, aes_done, out_ready,
      input  in_ready, aes_enable, aes_mode, aes_word, out_valid, out_data, out_last
   );
endinterface

// File: rtl/aes_blk_loader.sv
// Block loader between a word stream and an AES core, with ECB/CBC chaining.
// It works in four steps:
//   1. Packs IN_BW-bit words (MSB slot first) into a TXT_BW-bit block.
//   2. Issues the block to the core with a single registered aes_enable pulse.
//   3. Waits for aes_done, then applies the CBC output XOR.
//   4. Presents the result on a valid/ready stream.
// Ports:
//   - clk, srst_n: clock and asynchronous active-low reset.
//   - start, mode, cbc_en, iv: message start. mode, cbc_en and iv are sampled
//     when start is accepted in IDLE.
//   - busy: high in every state except IDLE.
//   - bus (slave): word input stream, AES core handshake, block output stream.
module aes_blk_loader #(
   parameter int unsigned TXT_BW = 128,
   parameter int unsigned IN_BW  = 32
) (
   input  logic              clk,
   input  logic              srst_n,
   input  logic              start,
   input  logic              mode,
   input  logic              cbc_en,
   input  logic [TXT_BW-1:0] iv,
   output logic              busy,
   aes_blk_loader_if.slave   bus
);

   localparam int unsigned NW   = TXT_BW / IN_BW;
   localparam int unsigned CntW = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic [2:0] {StIdle, StFill, StIssue, StWait, StOut} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic              cbc_q, cbc_d;
   logic              last_q, last_d;
   logic [TXT_BW-1:0] chain_q, chain_d;
   logic [TXT_BW-1:0] block_q, block_d;
   logic [TXT_BW-1:0] block_wr;
   logic              aes_enable_q, aes_enable_d;
   logic              aes_mode_q, aes_mode_d;
   logic [TXT_BW-1:0] aes_word_q, aes_word_d;
   logic [TXT_BW-1:0] out_data_q, out_data_d;

   // Block with the incoming word placed in the slot selected by cnt_q.
   always_comb begin
      block_wr = block_q;
      for (int unsigned i = 0; i < NW; i++) begin
         if (cnt_q == CntW'(i)) begin
            block_wr[(NW-1-i)*IN_BW +: IN_BW] = bus.in_data;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mode_d       = mode_q;
      cbc_d        = cbc_q;
      last_d       = last_q;
      chain_d      = chain_q;
      block_d      = block_q;
      aes_enable_d = 1'b0;
      aes_mode_d   = aes_mode_q;
      aes_word_d   = aes_word_q;
      out_data_d   = out_data_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               mode_d  = mode;
               cbc_d   = cbc_en;
               chain_d = iv;
               cnt_d   = '0;
               block_d = '0;
               last_d  = 1'b0;
               state_d = StFill;
            end
         end
         StFill: begin
            // in_ready is high throughout FILL, so in_valid alone accepts a word.
            if (bus.in_valid) begin
               block_d = block_wr;
               cnt_d   = cnt_q + 1'b1;
               if (bus.in_last || (cnt_q == CntW'(NW - 1))) begin
                  last_d       = bus.in_last;
                  aes_enable_d = 1'b1;
                  aes_mode_d   = mode_q;
                  // Encrypt-side CBC whitening happens before the core.
                  aes_word_d   = (cbc_q && !mode_q) ? (block_wr ^ chain_q) : block_wr;
                  state_d      = StIssue;
               end
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (bus.aes_done) begin
               // Decrypt-side CBC XOR happens after the core.
               out_data_d = (cbc_q && mode_q) ? (bus.aes_result ^ chain_q) : bus.aes_result;
               chain_d    = mode_q ? block_q : bus.aes_result;
               state_d    = StOut;
            end
         end
         StOut: begin
            if (bus.out_ready) begin
               if (last_q) begin
                  state_d = StIdle;
               end else begin
                  cnt_d   = '0;
                  block_d = '0;
                  state_d = StFill;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         mode_q       <= 1'b0;
         cbc_q        <= 1'b0;
         last_q       <= 1'b0;
         chain_q      <= '0;
         block_q      <= '0;
         aes_enable_q <= 1'b0;
         aes_mode_q   <= 1'b0;
         aes_word_q   <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mode_q       <= mode_d;
         cbc_q        <= cbc_d;
         last_q       <= last_d;
         chain_q      <= chain_d;
         block_q      <= block_d;
         aes_enable_q <= aes_enable_d;
         aes_mode_q   <= aes_mode_d;
         aes_word_q   <= aes_word_d;
         out_data_q   <= out_data_d;
      end
   end

   assign busy           = (state_q != StIdle);
   assign bus.in_ready   = (state_q == StFill);
   assign bus.aes_enable = aes_enable_q;
   assign bus.aes_mode   = aes_mode_q;
   assign bus.aes_word   = aes_word_q;
   assign bus.out_valid  = (state_q == StOut);
   assign bus.out_data   = out_data_q;
   // last_q persists into IDLE, so gate it with the OUT state.
   assign bus.out_last   = (state_q == StOut) && last_q;

endmodule
